// File: rtl/axis_weight_preload.sv
// axis_weight_preload: packs AXI4-Stream weight beats into 5*MAC_NUM-bit words and buffers them in a small FWFT FIFO.
// Optional build macro PRELOAD_TLAST_FLUSH_EN: an accepted tlast beat commits a short, zero-padded word.
module axis_weight_preload #(
    parameter integer MAC_NUM                 = 256,
    parameter integer AXIS_WIDTH              = 32,
    parameter integer AXIS_PRELOAD_FIFO_DEPTH = 4,
    // Equals clogb2(AXIS_PRELOAD_FIFO_DEPTH-1) for every depth >= 2.
    parameter integer bit_num                 = $clog2(AXIS_PRELOAD_FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXIS_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    preload_clear,
    input  logic                    axis_fifo_read,
    output logic [5*MAC_NUM-1:0]    weight_from_preload,
    output logic [bit_num:0]        axis_fifo_cnt,
    output logic                    partial_pending
);
    localparam integer WORD_W = 5 * MAC_NUM;
    localparam integer BEATS  = WORD_W / AXIS_WIDTH;
    localparam integer IDX_W  = $clog2(BEATS);
    localparam integer PTR_W  = $clog2(AXIS_PRELOAD_FIFO_DEPTH);
    localparam integer OFF_W  = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(AXIS_PRELOAD_FIFO_DEPTH - 1);
    localparam logic [bit_num:0]   FULL_CNT = (bit_num + 1)'(AXIS_PRELOAD_FIFO_DEPTH);

    logic [WORD_W-1:0] mem [AXIS_PRELOAD_FIFO_DEPTH];
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] word_in;
    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [bit_num:0]  cnt;
    logic [OFF_W-1:0]  off;
    logic              accept;
    logic              commit;
    logic              pop;

    assign s_axis_tready       = (cnt != FULL_CNT) && !preload_clear;
    assign accept              = s_axis_tvalid && s_axis_tready;
    assign pop                 = axis_fifo_read && (cnt != '0) && !preload_clear;
    assign axis_fifo_cnt       = cnt;
    assign partial_pending     = (idx != '0);
    assign weight_from_preload = mem[rd_ptr];
    assign off                 = OFF_W'(idx * AXIS_WIDTH);

`ifdef PRELOAD_TLAST_FLUSH_EN
    assign commit = accept && ((idx == LAST_IDX) || s_axis_tlast);
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign commit       = accept && (idx == LAST_IDX);
`endif

    // Current beat merged into the pack register; this is the word a commit writes.
    always_comb begin
        word_in = pack;
        word_in[off +: AXIS_WIDTH] = s_axis_tdata;
    end

    // Packer index, pack register, FIFO pointers and occupancy; clear overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            pack   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (preload_clear) begin
            idx    <= '0;
            pack   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                idx  <= commit ? '0 : idx + 1'b1;
                pack <= commit ? '0 : word_in;
            end
            if (commit)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            cnt <= (commit && !pop) ? cnt + 1'b1 : (pop && !commit) ? cnt - 1'b1 : cnt;
        end
    end

    // Word storage is not reset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (commit && rst_n)
            mem[wr_ptr] <= word_in;
    end
endmodule

// File: tb/tb_axis_weight_preload.sv
// tb_axis_weight_preload: table-driven and directed checks of axis_weight_preload against a queue scoreboard.
module tb_axis_weight_preload;
    localparam int MAC_NUM = 256;
    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int WW      = 5 * MAC_NUM;
    localparam int BEATS   = WW / AW;
`ifdef PRELOAD_TLAST_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          preload_clear = 1'b0;
    logic          axis_fifo_read = 1'b0;
    logic [WW-1:0] weight_from_preload;
    logic [2:0]    axis_fifo_cnt;
    logic          partial_pending;

    typedef struct {
        int beats;
        int reads;
        int cnt;
        bit partial;
        bit ready;
    } rec_t;

    rec_t          tbl[9];
    logic [WW-1:0] q[$];
    logic [WW-1:0] m_pack = '0;
    int            m_idx = 0;
    int            total = 0;
    int            bad = 0;
    bit            acc;

    axis_weight_preload #(
        .MAC_NUM(MAC_NUM),
        .AXIS_WIDTH(AW),
        .AXIS_PRELOAD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .preload_clear(preload_clear),
        .axis_fifo_read(axis_fifo_read),
        .weight_from_preload(weight_from_preload),
        .axis_fifo_cnt(axis_fifo_cnt),
        .partial_pending(partial_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] lane(input logic [WW-1:0] w, input int k);
        logic [WW-1:0] s;
        s = w >> (k * AW);
        return s[AW-1:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_word(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            for (int k = 0; k < BEATS; k++)
                if (lane(got, k) !== lane(exp, k)) begin
                    $display("FAIL %s lane=%0d got=%0h exp=%0h t=%0t", nm, k, lane(got, k), lane(exp, k), $time);
                    break;
                end
        end
    endtask

    // One clock: drive inputs, check tready, step the scoreboard, then check outputs after the edge.
    task automatic cycle(input bit v, input logic [AW-1:0] d, input bit l, input bit rd, input bit clr, output bit a);
        bit            rdy;
        bit            pop;
        bit            com;
        logic [WW-1:0] w;
        logic [WW-1:0] dropped;
        s_axis_tvalid  = v;
        s_axis_tdata   = d;
        s_axis_tlast   = l;
        axis_fifo_read = rd;
        preload_clear  = clr;
        #1;
        rdy = (q.size() != DEPTH) && !clr;
        check("tready", s_axis_tready, rdy);
        a   = v && rdy;
        pop = rd && (q.size() != 0) && !clr;
        com = 1'b0;
        w   = '0;
        @(posedge clk);
        #1;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        axis_fifo_read = 1'b0;
        preload_clear  = 1'b0;
        if (clr) begin
            q.delete();
            m_idx  = 0;
            m_pack = '0;
        end else begin
            if (a) begin
                m_pack = m_pack | (WW'(d) << (m_idx * AW));
                if (m_idx == BEATS - 1 || (FLUSH && l)) begin
                    w      = m_pack;
                    m_pack = '0;
                    m_idx  = 0;
                    com    = 1'b1;
                end else
                    m_idx++;
            end
            if (pop) dropped = q.pop_front();
            if (com) q.push_back(w);
        end
        check("cnt", axis_fifo_cnt, q.size());
        check("partial", partial_pending, m_idx != 0);
        if (q.size() != 0) check_word("head", weight_from_preload, q[0]);
    endtask

    // Send n beats with data base, base+1, ..., holding each until accepted, within a cycle budget.
    task automatic send(input int n, input int base);
        int sent  = 0;
        int spent = 0;
        bit a;
        while (sent < n && spent < 4 * n + 50) begin
            cycle(1'b1, AW'(base + sent), 1'b0, 1'b0, 1'b0, a);
            if (a) sent++;
            spent++;
        end
        total++;
        if (sent < n) begin
            bad++;
            $display("FAIL send_budget got=%0d exp=%0d", sent, n);
        end
    endtask

    task automatic clear();
        bit a;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    initial begin
        tbl[0] = '{40, 0, 1, 1'b0, 1'b1};
        tbl[1] = '{20, 0, 1, 1'b1, 1'b1};
        tbl[2] = '{20, 0, 2, 1'b0, 1'b1};
        tbl[3] = '{0, 1, 1, 1'b0, 1'b1};
        tbl[4] = '{120, 0, 4, 1'b0, 1'b0};
        tbl[5] = '{0, 2, 2, 1'b0, 1'b1};
        tbl[6] = '{0, 5, 0, 1'b0, 1'b1};
        tbl[7] = '{40, 0, 1, 1'b0, 1'b1};
        tbl[8] = '{7, 0, 1, 1'b1, 1'b1};

        #3;
        check("rst_tready", s_axis_tready, 1);
        check("rst_cnt", axis_fifo_cnt, 0);
        check("rst_partial", partial_pending, 0);
        preload_clear = 1'b1;
        #1;
        check("rst_clr_tready", s_axis_tready, 0);
        preload_clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_tready", s_axis_tready, 1);

        send(39, 0);
        check("w0_cnt_before", axis_fifo_cnt, 0);
        send(1, 39);
        check("w0_cnt_after", axis_fifo_cnt, 1);
        check("w0_lane0", lane(weight_from_preload, 0), 0);
        check("w0_lane39", lane(weight_from_preload, 39), 39);
        clear();

        for (int r = 0; r < 9; r++) begin
            if (tbl[r].beats != 0) send(tbl[r].beats, int'($urandom));
            for (int k = 0; k < tbl[r].reads; k++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            check($sformatf("tbl%0d_cnt", r), axis_fifo_cnt, tbl[r].cnt);
            check($sformatf("tbl%0d_partial", r), partial_pending, tbl[r].partial);
            check($sformatf("tbl%0d_tready", r), s_axis_tready, tbl[r].ready);
        end
        clear();

        send(160, 1000);
        check("full_cnt", axis_fifo_cnt, 4);
        check("full_tready", s_axis_tready, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'd161, 1'b0, 1'b0, 1'b0, acc);
            check("full_held_partial", partial_pending, 0);
        end
        cycle(1'b1, 32'd161, 1'b0, 1'b1, 1'b0, acc);
        check("full_pop_cnt", axis_fifo_cnt, 3);
        check("full_pop_tready", s_axis_tready, 1);
        cycle(1'b1, 32'd161, 1'b0, 1'b0, 1'b0, acc);
        check("full_161_partial", partial_pending, 1);
        clear();

        send(80, 2000);
        send(39, 3000);
        cycle(1'b1, 32'd3039, 1'b0, 1'b1, 1'b0, acc);
        check("cp_cnt", axis_fifo_cnt, 2);
        check("cp_head_lane0", lane(weight_from_preload, 0), 2040);
        clear();

        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            check("empty_read_cnt", axis_fifo_cnt, 0);
        end
        send(40, 100);
        check("after_empty_cnt", axis_fifo_cnt, 1);
        check("after_empty_lane0", lane(weight_from_preload, 0), 100);
        check("after_empty_lane39", lane(weight_from_preload, 39), 139);
        clear();

        send(6, 500);
        cycle(1'b1, 32'd506, 1'b1, 1'b0, 1'b0, acc);
`ifdef PRELOAD_TLAST_FLUSH_EN
        check("tlast_cnt", axis_fifo_cnt, 1);
        check("tlast_partial", partial_pending, 0);
        check("tlast_lane6", lane(weight_from_preload, 6), 506);
        check("tlast_lane7", lane(weight_from_preload, 7), 0);
        check("tlast_lane39", lane(weight_from_preload, 39), 0);
`else
        check("tlast_cnt", axis_fifo_cnt, 0);
        check("tlast_partial", partial_pending, 1);
`endif
        clear();

        send(80, 600);
        send(20, 700);
        check("clr_pre_partial", partial_pending, 1);
        cycle(1'b1, 32'd720, 1'b0, 1'b0, 1'b1, acc);
        check("clr_cnt", axis_fifo_cnt, 0);
        check("clr_partial", partial_pending, 0);
        send(40, 800);
        check("clr_word_cnt", axis_fifo_cnt, 1);
        check("clr_word_lane0", lane(weight_from_preload, 0), 800);

        send(20, 900);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", axis_fifo_cnt, 0);
        check("mid_rst_partial", partial_pending, 0);
        q.delete();
        m_idx  = 0;
        m_pack = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(40, 950);
        check("rst_word_cnt", axis_fifo_cnt, 1);
        check("rst_word_lane0", lane(weight_from_preload, 0), 950);
        check("rst_word_lane39", lane(weight_from_preload, 39), 989);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_weight_preload.md
# axis_weight_preload

Upstream stage of the weight BRAM controller. Accepts the weight stream from DMA on an AXI4-Stream slave port and packs consecutive beats into full 5*MAC_NUM-bit weight words (one 5-bit weight per MAC). Buffers the packed words in a small first-word-fall-through FIFO. The BRAM controller drains the FIFO through axis_fifo_cnt, axis_fifo_read and weight_from_preload.

## Interface
- MAC_NUM, 256, number of MACs; a word is 5*MAC_NUM bits
- AXIS_WIDTH, 32, s_axis_tdata width; 5*MAC_NUM must be an integer multiple ≥2 of it
- AXIS_PRELOAD_FIFO_DEPTH, 4, FIFO depth in words, ≥2
- bit_num, clogb2(AXIS_PRELOAD_FIFO_DEPTH-1), count MSB index
- Derived: BEATS = 5*MAC_NUM/AXIS_WIDTH (40 at defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  AXIS_WIDTH  weight stream data
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready at a rising edge
- s_axis_tlast  in  1  end of weight transfer
- preload_clear  in  1  synchronous flush of packer and FIFO
- axis_fifo_read  in  1  pop request from the BRAM controller
- weight_from_preload  out  5*MAC_NUM  FIFO head word
- axis_fifo_cnt  out  bit_num+1  words held, 0..AXIS_PRELOAD_FIFO_DEPTH
- partial_pending  out  1  packer holds ≥1 beat of an uncommitted word

## Operation
- Packer: beat index idx (0..BEATS-1) and a pack register. An accepted beat writes bits [idx*AXIS_WIDTH +: AXIS_WIDTH]. Beat 0 goes to the LSBs.
- When the beat with idx = BEATS-1 is accepted, the assembled word (including that beat) is written to the FIFO at wr_ptr. On the same edge: wr_ptr advances, count +1, idx returns to 0.
- s_axis_tready = (axis_fifo_cnt != DEPTH) && !preload_clear. This depends only on current state, not on axis_fifo_read in the same cycle. While the FIFO is full, partial-word beats also stall.
- Pop: axis_fifo_read && cnt != 0 advances rd_ptr and decrements count. axis_fifo_read with cnt == 0 is ignored. The controller asserts read in states where the FIFO may be empty, so this case is normal.
- Commit and pop on the same edge: count unchanged, both pointers advance.
- Pointers wrap explicitly from DEPTH-1 to 0. DEPTH need not be a power of 2.
- weight_from_preload = mem[rd_ptr], read combinationally. It is meaningful only while cnt != 0. Memory is not reset.
- partial_pending = (idx != 0).
- preload_clear takes priority over push and pop. On the next edge: idx, pointers and count go to 0, and the pack register contents are discarded.

## Timing
- Reset values: axis_fifo_cnt 0, partial_pending 0, idx 0, pointers 0. s_axis_tready is 1 immediately after rst_n rises; while rst_n is low it follows the reset state (1 unless preload_clear is high). weight_from_preload is don't-care.
- Latency: the edge that accepts the last beat updates count. In the following cycle cnt != 0 and weight_from_preload shows the new word.
- Pop: the head updates to the next entry one cycle after the pop edge. Back-to-back pops on consecutive cycles are supported (controller states WS0 then WS1).
- Reset asserted mid-word or mid-transfer: all state is lost immediately. No partial word is committed.

## Configuration
- PRELOAD_TLAST_FLUSH_EN defined: an accepted beat with s_axis_tlast=1 and idx < BEATS-1 commits the word immediately. Bits above that beat are zero, idx returns to 0, and count +1.
- tlast on beat BEATS-1 behaves as a normal commit.
- PRELOAD_TLAST_FLUSH_EN undefined: s_axis_tlast is ignored. Words commit only on full BEATS.

## Test plan
- Defaults: 40 beats with tdata = beat number, no reads → cnt goes 0→1 on the 40th acceptance edge; the head word has bits [31:0]=0 and [1279:1248]=39.
- 160 beats, no reads → cnt=4, tready=0, beat 161 is held. A single pop → cnt=3 on the next edge, tready=1, and beat 161 is accepted.
- cnt=2 with the 40th beat of word 3 and axis_fifo_read on the same edge → cnt stays 2 and the head becomes word 2.
- cnt=0 with axis_fifo_read=1 for 5 cycles → cnt stays 0. A subsequent word is read correctly as the head.
- tlast on beat 6 (idx 6): with the macro, cnt=1, bits [223:0] = beats 0–6 and [1279:224]=0, partial_pending=0. Without the macro, cnt=0 and partial_pending=1 (idx=7).
- preload_clear pulsed at idx=20 with cnt=2 → next edge cnt=0, partial_pending=0. The following 40 beats form a clean word. rst_n pulled low mid-word gives the same result.
